// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable oversampled UART receiver with show-ahead RX FIFO
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (needs OVERSAMPLE >= 8).
module uart_rx_cfg #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_two_stop,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic             rxd_meta_q, rxd_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_last;
  logic             tick, sample, bit_val, bit_end;

  state_e           state_q, state_d;
  logic [SW-1:0]    samp_q, samp_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [1:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
  logic             push, push_ferr;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overrun_q, full, pop, wr_en;
  logic [9:0]       head;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      div_cnt_q  <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      div_cnt_q  <= tick ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  // >= rather than == so a divisor lowered on the fly cannot strand the counter above its terminal count
  assign div_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick     = (div_cnt_q >= div_last);
  assign bit_end  = tick && (samp_q == LAST);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      early_q <= 2'b11;
    end else if (tick) begin
      if (samp_q == MID - SW'(1)) early_q[0] <= rxd_sync_q;
      if (samp_q == MID)          early_q[1] <= rxd_sync_q;
    end
  end
  assign sample  = tick && (samp_q == MID + SW'(1));
  assign bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rxd_sync_q) | (early_q[1] & rxd_sync_q);
`else
  assign sample  = tick && (samp_q == MID);
  assign bit_val = rxd_sync_q;
`endif

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    push       = 1'b0;
    push_ferr  = ferr_q | ~bit_val;
    if (tick && state_q != IDLE) samp_d = samp_q + SW'(1);
    case (state_q)
      IDLE: begin
        if (tick && !rxd_sync_q) begin
          state_d    = START;
          samp_d     = '0;
          bit_cnt_d  = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop_cnt_d = 1'b0;
          nbits_d    = cfg_data_bits;
          par_en_d   = cfg_parity_en;
          par_odd_d  = cfg_parity_odd;
          two_stop_d = cfg_two_stop;
        end
      end
      START: begin
        if (sample && bit_val) state_d = IDLE;
        else if (bit_end)      state_d = DATA;
      end
      DATA: begin
        if (sample) data_d[bit_cnt_q] = bit_val;
        if (bit_end) begin
          if (bit_cnt_q == {1'b0, nbits_q} + 3'd4) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample)  perr_d  = ((^data_q) ^ bit_val) != par_odd_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (sample) begin
          ferr_d = push_ferr;
          if (stop_cnt_q == two_stop_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        if (bit_end) stop_cnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
    end
  end

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {data_q, perr_q, push_ferr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overrun_q <= 1'b1;
      else if (clr_overrun)     overrun_q <= 1'b0;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? head[9:2] : 8'h00;
  assign rx_perr    = rx_valid & head[1];
  assign rx_ferr    = rx_valid & head[0];
  assign overrun    = overrun_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg
// Frames are driven bit-by-bit with a whole number of receiver ticks per bit.
module tb_uart_rx_cfg;
  logic        clk = 1'b0;
  logic        reset, rxd;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic        rx_valid, rx_perr, rx_ferr, rx_ready, overrun, clr_overrun;
  logic [7:0]  rx_data;
  logic [3:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;
  int bit_cyc;
  int popped;
  bit done;

  always #5 clk = ~clk;

  uart_rx_cfg #(.OVERSAMPLE(16), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_ready(rx_ready), .overrun(overrun), .clr_overrun(clr_overrun),
    .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    step(bit_cyc);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_en,
                            input logic par_bit, input bit two_stop, input logic stop2);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(1'b1);
    if (two_stop) drive_bit(stop2);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; baud_div = 16'd27; bit_cyc = 27 * 16;
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
    rx_ready = 1'b0; clr_overrun = 1'b0;
    step(4);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_perr", rx_perr, 0);
    check("reset_ferr", rx_ferr, 0);
    check("reset_overrun", overrun, 0);
    check("reset_level", fifo_level, 0);
    reset = 1'b0;
    step(4);

    // 8N1 at divisor 27
    send_frame(8'hA5, 8, 0, 1'b0, 0, 1'b1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_perr", rx_perr, 0);
    check("a5_ferr", rx_ferr, 0);
    check("a5_level", fifo_level, 1);
    pop_one();
    check("a5_popped_valid", rx_valid, 0);

    baud_div = 16'd4; bit_cyc = 4 * 16;
    step(bit_cyc);

    // 7E1 with wrong parity bit, then 7O1 with correct parity bit
    cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    send_frame(8'h55, 7, 1, 1'b1, 0, 1'b1);
    check("7e_data", rx_data, 8'h55);
    check("7e_perr", rx_perr, 1);
    check("7e_ferr", rx_ferr, 0);
    pop_one();
    cfg_parity_odd = 1'b1;
    send_frame(8'h55, 7, 1, 1'b1, 0, 1'b1);
    check("7o_data", rx_data, 8'h55);
    check("7o_perr", rx_perr, 0);
    pop_one();

    // 8N2 with bad second stop bit, then a clean 8N2 frame
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b1;
    send_frame(8'h96, 8, 0, 1'b0, 1, 1'b0);
    check("8n2_bad_ferr", rx_ferr, 1);
    check("8n2_bad_data", rx_data, 8'h96);
    check("8n2_bad_perr", rx_perr, 0);
    check("8n2_bad_level", fifo_level, 1);
    pop_one();
    send_frame(8'h3A, 8, 0, 1'b0, 1, 1'b1);
    check("8n2_ok_ferr", rx_ferr, 0);
    check("8n2_ok_data", rx_data, 8'h3A);
    check("8n2_ok_level", fifo_level, 1);
    pop_one();

    // 3-tick glitch in idle
    cfg_two_stop = 1'b0;
    rxd = 1'b0;
    step(12);
    rxd = 1'b1;
    step(3 * bit_cyc);
    check("glitch_level", fifo_level, 0);
    check("glitch_valid", rx_valid, 0);

    // fill the FIFO and drop the ninth frame
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 8, 0, 1'b0, 0, 1'b1);
    check("full_level", fifo_level, 8);
    check("full_overrun", overrun, 1);
    check("full_head", rx_data, 8'h10);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    check("clr_overrun", overrun, 0);

    // pop in the same cycle as the push of frame 10
    done = 1'b0;
    popped = 0;
    fork
      begin
        send_frame(8'h1A, 8, 0, 1'b0, 0, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rx_ready = dut.push;
          if (dut.push) popped++;
        end
        rx_ready = 1'b0;
      end
    join
    check("simul_pop_count", popped, 1);
    check("simul_level", fifo_level, 8);
    check("simul_overrun", overrun, 0);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h1A);
      pop_one();
    end
    check("drain_level", fifo_level, 0);

    // reset during data bit 4, then a clean frame
    send_frame(8'h77, 8, 0, 1'b0, 0, 1'b1);
    check("pre_reset_level", fifo_level, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h3C >> i);
    rxd = 1'b1;
    step(bit_cyc / 2);
    reset = 1'b1;
    step(1);
    check("midreset_valid", rx_valid, 0);
    check("midreset_data", rx_data, 0);
    check("midreset_perr", rx_perr, 0);
    check("midreset_ferr", rx_ferr, 0);
    check("midreset_overrun", overrun, 0);
    check("midreset_level", fifo_level, 0);
    reset = 1'b0;
    rxd = 1'b1;
    step(3 * bit_cyc);
    check("post_reset_empty", fifo_level, 0);
    send_frame(8'h3C, 8, 0, 1'b0, 0, 1'b1);
    check("post_reset_valid", rx_valid, 1);
    check("post_reset_data", rx_data, 8'h3C);
    check("post_reset_ferr", rx_ferr, 0);
    check("post_reset_level", fifo_level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver with oversampled start/bit detection, 5–8 data bits, optional parity, 1 or 2 stop bits, error reporting and an output FIFO with valid/ready pop handshake. It sits between the RxD pin and the MCU peripheral bus. Software programs the divisor and frame format through CSRs.

Parameters:
OVERSAMPLE, 16, ticks per bit; power of two, 4..16
FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..32
DIV_W, 16, width of baud divisor

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
rxd  in  1  asynchronous serial input, idle high
baud_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
cfg_data_bits  in  2  data bits = 5 + value (0→5 … 3→8)
cfg_parity_en  in  1  parity bit present
cfg_parity_odd  in  1  1 = odd parity, 0 = even parity
cfg_two_stop  in  1  1 = two stop bits
rx_valid  out  1  FIFO not empty
rx_data  out  8  head-of-FIFO data, LSB = first received bit, unused upper bits 0
rx_perr  out  1  parity error flag of head entry
rx_ferr  out  1  framing error flag of head entry
rx_ready  in  1  pop head when rx_valid & rx_ready
overrun  out  1  sticky: a frame was dropped because FIFO full
clr_overrun  in  1  clears overrun
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- rxd passes through a 2-flop synchroniser (reset to 1) before any use; latency 2 cycles.
- Tick generator: counter 0..baud_div-1 free-running when reset is low; one-cycle tick at terminal count.
- Mid-sample point: tick index OVERSAMPLE/2-1 within a bit. Bit period: OVERSAMPLE ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with synchronised rxd = 0 → START, sample counter cleared.
- START: at mid-sample, rxd = 1 → IDLE (false start, nothing pushed); rxd = 0 → continue; after full bit → DATA.
- DATA: sample at mid-point, shift in LSB first; after (5+cfg_data_bits) bits → PARITY if cfg_parity_en, else STOP.
- PARITY: sample; perr = (XOR of data bits ^ sampled bit) != cfg_parity_odd. With parity disabled, perr = 0.
- STOP: sample at mid-point of each stop bit; ferr = any stop sample 0. After the mid-sample of the last stop bit, push {data, perr, ferr} and → IDLE in the same cycle, so the receiver resyncs before the next start edge.
- Config inputs are sampled at START entry and held for the frame; mid-frame changes apply from the next frame.
- FIFO: show-ahead. rx_data, rx_perr and rx_ferr are valid whenever rx_valid = 1. Pop on rx_valid & rx_ready.
- Push while full and no pop in that cycle: frame dropped, FIFO unchanged, overrun set.
- Push while full with a pop in the same cycle: both succeed, level unchanged.
- Push and pop in the same cycle when not full: level unchanged.
- overrun: set has priority over clr_overrun in the same cycle.
- Reset values: rx_valid 0, rx_data 0, rx_perr 0, rx_ferr 0, overrun 0, fifo_level 0, FSM IDLE, all counters 0. Reset mid-frame aborts the frame; no partial push.

Optional Feature:
UART_RX_MAJORITY_EN — when defined, each bit value is the 2-of-3 majority of samples at ticks mid-1, mid and mid+1, and a glitch test in START uses the majority value. Requires OVERSAMPLE ≥ 8. When undefined, a single sample is taken at mid.

Test Plan:
- baud_div=27, 8N1, send 0xA5 → after frame, rx_valid=1, rx_data=0xA5, perr=0, ferr=0, fifo_level=1; pop → rx_valid=0.
- 7 data bits, even parity, send 0x55 with wrong parity bit → rx_data=0x55, rx_perr=1; repeat with odd parity and correct bit → rx_perr=0.
- 8N2, second stop bit driven 0 → rx_ferr=1, rx_data is still the received byte; next frame is received correctly.
- Low pulse of 3 ticks on rxd in IDLE → no push, FSM back to IDLE, fifo_level stays 0.
- FIFO_DEPTH=8, send 9 frames without pop → fifo_level=8, overrun=1, head is frame 1; clr_overrun → 0. Send frame 10 while popping in the same cycle as the push → accepted, level stays 8.
- Assert reset during data bit 4 → all outputs at reset values next cycle; the following full frame 0x3C is received correctly.
